// File: rtl/tone_div_pkg.sv
// -----------------------------------------------------------------------------
// tone_div_pkg
// Shared definitions for the tone divider calculator:
//   - octave codes presented by music_example
//   - FSM state encoding used by tone_div_calc
//   - default system clock rate used as the dividend constant
// -----------------------------------------------------------------------------
package tone_div_pkg;

    localparam int CLK_HZ_DEFAULT = 50000000;

    localparam logic [2:0] OCT_DOWN = 3'd1;
    localparam logic [2:0] OCT_NOM  = 3'd2;
    localparam logic [2:0] OCT_UP   = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DIV_L,
        DIV_R,
        UPDATE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Restoring divider producing one quotient bit per clock, MSB first.
// The start cycle already performs the first iteration, so the quotient is
// complete DVD_W edges after start and done pulses in the following cycle.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        load operands and run the first iteration
//   dividend     DVD_W-bit dividend (sampled on start)
//   divisor      DSR_W-bit divisor (sampled on start)
//   quotient     DVD_W-bit result, valid while done is high and until next start
//   div_zero     divisor was zero for the current/last operation
//   done         one-cycle pulse once the quotient is complete
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int DVD_W = 26,
    parameter int DSR_W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             div_zero,
    output logic             done
);

    localparam int               CNT_W     = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DVD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [DSR_W-1:0] rem_q, dsr_q;
    logic [DSR_W-1:0] src_rem, src_dsr, rem_nxt;
    logic [DVD_W-1:0] quo_q, src_quo, quo_nxt;
    logic [DSR_W:0]   rem_shift;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q, dz_q, done_q;
    logic             fits;

    // One restoring step. On start the step works straight from the new
    // operands so no separate load cycle is needed.
    always_comb begin
        src_rem   = start ? '0       : rem_q;
        src_quo   = start ? dividend : quo_q;
        src_dsr   = start ? divisor  : dsr_q;
        rem_shift = {src_rem, src_quo[DVD_W-1]};
        fits      = (rem_shift >= {1'b0, src_dsr});
        rem_nxt   = fits ? DSR_W'(rem_shift - {1'b0, src_dsr}) : rem_shift[DSR_W-1:0];
        quo_nxt   = {src_quo[DVD_W-2:0], fits};
    end

    // Iteration counter and working registers; done fires after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                dsr_q <= divisor;
                dz_q  <= (divisor == '0);
                cnt_q <= ITER_LAST;
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;
    assign div_zero = dz_q;
    assign done     = done_q;

endmodule

// File: rtl/tone_div_calc.sv
// -----------------------------------------------------------------------------
// tone_div_calc
// Sequential CLK_HZ / freq stage feeding note_gen. Scales each raw tone by the
// octave code, divides the clock rate by it with one shared seq_divider (left
// then right), and updates both divider outputs together.
//
// Optional feature macro: TONE_DIV_ROUND_EN
//   defined   -> dividend = CLK_HZ + divisor/2 (round to nearest)
//   undefined -> dividend = CLK_HZ (truncate)
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tone_l, tone_r  raw left/right frequencies in Hz
//   octave          1 = down one octave, 3 = up one octave, else nominal
//   note_div_left   left divider value (saturates at all ones)
//   note_div_right  right divider value (saturates at all ones)
//   busy            computation in progress
//   div_valid       one-cycle pulse when both outputs update
// -----------------------------------------------------------------------------
module tone_div_calc
    import tone_div_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int FREQ_W = 32,
    parameter int DVD_W  = 26,
    parameter int DIV_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] tone_l,
    input  logic [FREQ_W-1:0] tone_r,
    input  logic [2:0]        octave,
    output logic [DIV_W-1:0]  note_div_left,
    output logic [DIV_W-1:0]  note_div_right,
    output logic              busy,
    output logic              div_valid
);

    localparam int DSR_W = FREQ_W + 1;

    state_t state, state_nxt;

    logic [FREQ_W-1:0] tone_l_q, tone_r_q;
    logic [2:0]        octave_q;
    logic              pending;

    logic [DSR_W-1:0]  dsr_l_live, dsr_r_live, div_r_q, div_divisor;
    logic [DVD_W-1:0]  div_dividend, div_quotient;
    logic              div_zero, div_done, div_start;
    logic              latch_inputs, use_left, cap_l, cap_r, do_update;
    logic [DIV_W-1:0]  res_l_q, res_r_q, chan_result;

    function automatic logic [DSR_W-1:0] scale_tone(input logic [FREQ_W-1:0] tone,
                                                    input logic [2:0]        oct);
        case (oct)
            OCT_DOWN: return {2'b00, tone[FREQ_W-1:1]};
            OCT_UP:   return {tone, 1'b0};
            OCT_NOM:  return {1'b0, tone};
            default:  return {1'b0, tone};
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] saturate(input logic [DVD_W-1:0] q,
                                                  input logic             dz);
        if (dz || ((q >> DIV_W) != '0)) return '1;
        return q[DIV_W-1:0];
    endfunction

    assign dsr_l_live  = scale_tone(tone_l, octave);
    assign dsr_r_live  = scale_tone(tone_r, octave);
    assign pending     = (tone_l != tone_l_q) || (tone_r != tone_r_q) || (octave != octave_q);
    assign div_divisor = use_left ? dsr_l_live : div_r_q;

`ifdef TONE_DIV_ROUND_EN
    // A large divisor can push CLK_HZ + divisor/2 past the DVD_W-bit dividend.
    // The true quotient is then 0 or 1, decided directly instead of dividing.
    logic [DSR_W:0] round_sum;
    logic           ovf_live, one_live, ovf_q, one_q;

    always_comb begin
        round_sum    = (DSR_W+1)'(CLK_HZ) + {1'b0, div_divisor >> 1};
        div_dividend = round_sum[DVD_W-1:0];
        ovf_live     = |round_sum[DSR_W:DVD_W];
        one_live     = ({1'b0, div_divisor} <= (DSR_W+1)'(2 * CLK_HZ));
        chan_result  = ovf_q ? {{(DIV_W-1){1'b0}}, one_q} : saturate(div_quotient, div_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            one_q <= 1'b0;
        end else if (div_start) begin
            ovf_q <= ovf_live;
            one_q <= one_live;
        end
    end
`else
    assign div_dividend = DVD_W'(CLK_HZ);
    assign chan_result  = saturate(div_quotient, div_zero);
`endif

    seq_divider #(
        .DVD_W (DVD_W),
        .DSR_W (DSR_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .div_zero (div_zero),
        .done     (div_done)
    );

    // State register; reset lands in START so a computation always follows.
    always_ff @(posedge clk) begin
        if (rst) state <= START;
        else     state <= state_nxt;
    end

    // Next state and datapath strobes. The right division is launched in the
    // same cycle the left quotient is captured, keeping each phase DVD_W long.
    always_comb begin
        state_nxt    = state;
        div_start    = 1'b0;
        use_left     = 1'b0;
        latch_inputs = 1'b0;
        cap_l        = 1'b0;
        cap_r        = 1'b0;
        do_update    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) state_nxt = START;
            end
            START: begin
                latch_inputs = 1'b1;
                div_start    = 1'b1;
                use_left     = 1'b1;
                state_nxt    = DIV_L;
            end
            DIV_L: begin
                if (div_done) begin
                    cap_l     = 1'b1;
                    div_start = 1'b1;
                    state_nxt = DIV_R;
                end
            end
            DIV_R: begin
                if (div_done) begin
                    cap_r     = 1'b1;
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                do_update = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input copies, per-channel results and the outputs presented to note_gen.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_l_q       <= '0;
            tone_r_q       <= '0;
            octave_q       <= '0;
            div_r_q        <= '0;
            res_l_q        <= '0;
            res_r_q        <= '0;
            note_div_left  <= '0;
            note_div_right <= '0;
            busy           <= 1'b0;
            div_valid      <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            if (latch_inputs) begin
                tone_l_q <= tone_l;
                tone_r_q <= tone_r;
                octave_q <= octave;
                div_r_q  <= dsr_r_live;
                busy     <= 1'b1;
            end
            if (cap_l) res_l_q <= chan_result;
            if (cap_r) res_r_q <= chan_result;
            if (do_update) begin
                note_div_left  <= res_l_q;
                note_div_right <= res_r_q;
                div_valid      <= 1'b1;
                busy           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_div_calc.sv
// -----------------------------------------------------------------------------
// tb_tone_div_calc
// Self-checking bench for tone_div_calc: directed vector table, randomized
// vectors against an arithmetic reference, plus latency, mid-computation input
// change and mid-computation reset sequences.
// -----------------------------------------------------------------------------
module tb_tone_div_calc;

    localparam logic [21:0] SAT = 22'h3FFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tone_l, tone_r;
    logic [2:0]  octave;
    logic [21:0] note_div_left, note_div_right;
    logic        busy, div_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] tl;
        logic [31:0] tr;
        logic [2:0]  oc;
        logic [21:0] el;
        logic [21:0] er;
    } vec_t;

    vec_t vecs[10];

    tone_div_calc dut (
        .clk            (clk),
        .rst            (rst),
        .tone_l         (tone_l),
        .tone_r         (tone_r),
        .octave         (octave),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .busy           (busy),
        .div_valid      (div_valid)
    );

    always #5 clk = ~clk;

    // Reference: 50 MHz divided by the octave-scaled tone, clamped to 22 bits.
    function automatic logic [21:0] refDiv(input logic [31:0] tone, input logic [2:0] oct);
        longint unsigned d, q, t;
        t = {32'd0, tone};
        if (oct == 3'd1)      d = t / 2;
        else if (oct == 3'd3) d = t * 2;
        else                  d = t;
        if (d == 0) return SAT;
`ifdef TONE_DIV_ROUND_EN
        q = (64'd50000000 + d / 2) / d;
`else
        q = 64'd50000000 / d;
`endif
        if (q > 64'(SAT)) return SAT;
        return q[21:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] tl, input logic [31:0] tr,
                                 input logic [2:0] oc);
        @(posedge clk);
        #1;
        tone_l = tl;
        tone_r = tr;
        octave = oc;
    endtask

    task automatic waitValid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (div_valid) seen = 1'b1;
        end
    endtask

    task automatic runVector(input string name, input logic [31:0] tl, input logic [31:0] tr,
                             input logic [2:0] oc, input logic [21:0] el, input logic [21:0] er);
        bit seen;
        applyStimulus(tl, tr, oc);
        waitValid(200, seen);
        checkOutput({name, "_valid"}, 64'(seen), 64'd1);
        checkOutput({name, "_left"}, 64'(note_div_left), 64'(el));
        checkOutput({name, "_right"}, 64'(note_div_right), 64'(er));
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput({name, "_pulse"}, 64'(div_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        logic [21:0] p_l[2];
        logic [21:0] p_r[2];
        bit seen;
        logic [31:0] tl, tr;
        logic [2:0]  oc;

        vecs[0] = '{32'd262, 32'd440, 3'd3, 22'd95419, 22'd56818};
`ifdef TONE_DIV_ROUND_EN
        vecs[0].el = 22'd95420;
`endif
        vecs[1] = '{32'd880, 32'd0, 3'd1, 22'd113636, SAT};
        vecs[2] = '{32'd1, 32'd0, 3'd2, SAT, SAT};
        vecs[3] = '{32'd1, 32'd0, 3'd1, SAT, SAT};
        vecs[4] = '{32'd12, 32'd12, 3'd2, 22'd4166666, 22'd4166666};
`ifdef TONE_DIV_ROUND_EN
        vecs[4].el = 22'd4166667;
        vecs[4].er = 22'd4166667;
`endif
        vecs[5] = '{32'd11, 32'd11, 3'd2, SAT, SAT};
        vecs[6] = '{32'd440, 32'd494, 3'd5, 22'd113636, 22'd101214};
`ifdef TONE_DIV_ROUND_EN
        vecs[6].er = 22'd101215;
`endif
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 22'd0, 22'd0};
        vecs[8] = '{32'd440, 32'd440, 3'd0, 22'd113636, 22'd113636};
        vecs[9] = '{32'd24, 32'd13, 3'd1, 22'd4166666, SAT};
`ifdef TONE_DIV_ROUND_EN
        vecs[9].el = 22'd4166667;
`endif

        // Reset state, then exact latency of the forced first computation.
        rst    = 1'b1;
        tone_l = 32'd440;
        tone_r = 32'd440;
        octave = 3'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_left", 64'(note_div_left), 64'd0);
        checkOutput("reset_right", 64'(note_div_right), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_valid", 64'(div_valid), 64'd0);
        rst = 1'b0;
        repeat (53) @(posedge clk);
        @(negedge clk);
        checkOutput("lat53_left", 64'(note_div_left), 64'd0);
        checkOutput("lat53_busy", 64'(busy), 64'd1);
        checkOutput("lat53_valid", 64'(div_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat54_left", 64'(note_div_left), 64'd113636);
        checkOutput("lat54_right", 64'(note_div_right), 64'd113636);
        checkOutput("lat54_valid", 64'(div_valid), 64'd1);
        checkOutput("lat54_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("lat55_valid", 64'(div_valid), 64'd0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].tl, vecs[i].tr, vecs[i].oc,
                      vecs[i].el, vecs[i].er);
        end

        // Randomized vectors against the reference.
        for (int i = 0; i < 24; i++) begin
            tl = 32'($urandom_range(1, 20000));
            tr = 32'($urandom_range(0, 20000));
            oc = 3'($urandom_range(0, 7));
            if (tl == tone_l && tr == tone_r && oc == octave) tl = tl + 32'd1;
            runVector($sformatf("rnd%0d", i), tl, tr, oc, refDiv(tl, oc), refDiv(tr, oc));
        end

        // Input change during DIV_L: first result unaffected, one recompute.
        runVector("pre_change", 32'd440, 32'd440, 3'd2, 22'd113636, 22'd113636);
        applyStimulus(32'd880, 32'd440, 3'd2);
        repeat (11) @(posedge clk);
        #1;
        tone_r = 32'd494;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (div_valid) begin
                if (pulses < 2) begin
                    p_l[pulses] = note_div_left;
                    p_r[pulses] = note_div_right;
                end
                pulses++;
            end
        end
        checkOutput("chg_pulses", 64'(pulses), 64'd2);
        checkOutput("chg_first_left", 64'(p_l[0]), 64'(refDiv(32'd880, 3'd2)));
        checkOutput("chg_first_right", 64'(p_r[0]), 64'd113636);
        checkOutput("chg_second_left", 64'(p_l[1]), 64'(refDiv(32'd880, 3'd2)));
        checkOutput("chg_second_right", 64'(p_r[1]), 64'(refDiv(32'd494, 3'd2)));

        // Reset during DIV_R: abort, clear, then a full forced recompute.
        applyStimulus(32'd440, 32'd494, 3'd2);
        repeat (35) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mid_left", 64'(note_div_left), 64'd0);
        checkOutput("rst_mid_right", 64'(note_div_right), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_valid", 64'(div_valid), 64'd0);
        waitValid(200, seen);
        checkOutput("rst_rec_valid", 64'(seen), 64'd1);
        checkOutput("rst_rec_left", 64'(note_div_left), 64'd113636);
        checkOutput("rst_rec_right", 64'(note_div_right), 64'(refDiv(32'd494, 3'd2)));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
